// File: rtl/alarm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : alarm_sched_pkg
// Brief  : Shared state encoding, time limits and helpers for alarm_sched.
// Rev    : 1.0
// ============================================================================
package alarm_sched_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam logic [5:0] HOURS_MAX = 6'd23;
  localparam logic [5:0] MINS_MAX  = 6'd59;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] mins;
  } hm_t;

  function automatic logic time_valid(input logic [5:0] h, input logic [5:0] m);
    return (h <= HOURS_MAX) && (m <= MINS_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_sched_if.sv
`default_nettype none
// ============================================================================
// Module : alarm_sched_if
// Brief  : Time, configuration, button and status bundle of the alarm block.
// Rev    : 1.0
// ============================================================================
interface alarm_sched_if #(
  parameter int NUM_SLOTS = 4
);
  logic                 minute_tick;
  logic [5:0]           cur_hours;
  logic [5:0]           cur_minutes;
  logic                 cfg_we;
  logic [1:0]           cfg_slot;
  logic [5:0]           cfg_hours;
  logic [5:0]           cfg_minutes;
  logic                 cfg_enable;
  logic                 snooze_btn;
  logic                 stop_btn;
  logic                 ring;
  logic [1:0]           ring_slot;
  logic                 snoozed;
  logic [NUM_SLOTS-1:0] slot_en;

  modport master (
    output minute_tick, cur_hours, cur_minutes,
    output cfg_we, cfg_slot, cfg_hours, cfg_minutes, cfg_enable,
    output snooze_btn, stop_btn,
    input  ring, ring_slot, snoozed, slot_en
  );

  modport slave (
    input  minute_tick, cur_hours, cur_minutes,
    input  cfg_we, cfg_slot, cfg_hours, cfg_minutes, cfg_enable,
    input  snooze_btn, stop_btn,
    output ring, ring_slot, snoozed, slot_en
  );
endinterface
`default_nettype wire

// File: rtl/alarm_sched_time_add_wrap.sv
`default_nettype none
// ============================================================================
// Module : time_add_wrap
// Brief  : hh:mm + minutes, minutes wrap mod 60 into hours, hours wrap mod 24.
// Rev    : 1.0
// ============================================================================
module time_add_wrap
  import alarm_sched_pkg::*;
(
  input  logic [5:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_add_min,
  output logic [5:0] o_hours,
  output logic [5:0] o_minutes
);

  logic [6:0] w_min_sum;
  logic [6:0] w_min_wrap;
  logic       w_carry;
  logic [5:0] w_hour_inc;

  // Addend is at most 59, so a single subtract of 60 is enough.
  always_comb begin
    w_min_sum  = {1'b0, i_minutes} + {1'b0, i_add_min};
    w_carry    = (w_min_sum > {1'b0, MINS_MAX});
    w_min_wrap = w_min_sum - 7'd60;
    o_minutes  = w_carry ? w_min_wrap[5:0] : w_min_sum[5:0];
    w_hour_inc = i_hours + {5'd0, w_carry};
    o_hours    = (w_hour_inc > HOURS_MAX) ? 6'd0 : w_hour_inc;
  end

endmodule
`default_nettype wire

// File: rtl/alarm_sched.sv
`default_nettype none
// ============================================================================
// Module : alarm_sched
// Brief  : Multi-slot alarm clock sharing one ringer, with snooze and timeout.
// Rev    : 1.0
// ============================================================================
module alarm_sched
  import alarm_sched_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 10,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic         count,
  input  logic         reset_in_n,
  alarm_sched_if.slave bus
);

  localparam int TO_W = (RING_TIMEOUT < 2) ? 1 : $clog2(RING_TIMEOUT + 1);
  localparam int SN_W = (MAX_SNOOZE < 2) ? 1 : $clog2(MAX_SNOOZE + 1);

  localparam logic [TO_W-1:0] c_to_last   = TO_W'(RING_TIMEOUT - 1);
  localparam logic [SN_W-1:0] c_sn_max    = SN_W'(MAX_SNOOZE);
  localparam logic [5:0]      c_snz_min   = 6'(SNOOZE_MIN);

  logic [5:0]           r_slot_h [NUM_SLOTS];
  logic [5:0]           r_slot_m [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_slot_en;

  logic [1:0]      r_state;
  logic            r_ring;
  logic            r_snoozed;
  logic [1:0]      r_ring_slot;
  logic [TO_W-1:0] r_to_cnt;
  logic [SN_W-1:0] r_sn_cnt;
  hm_t             r_wake;

  logic [1:0]      w_state_nxt;
  logic [1:0]      w_slot_nxt;
  logic [TO_W-1:0] w_to_nxt;
  logic [SN_W-1:0] w_sn_nxt;
  hm_t             w_wake_nxt;
  hm_t             w_snz;

  logic            w_cfg_ok;
  logic            w_hit;
  logic [1:0]      w_hit_idx;
  logic [5:0]      w_act_h;
  logic [5:0]      w_act_m;
  logic            w_act_cfg;
  logic            w_wake_eq;

  time_add_wrap u_snz_add (
    .i_hours   (bus.cur_hours),
    .i_minutes (bus.cur_minutes),
    .i_add_min (c_snz_min),
    .o_hours   (w_snz.hours),
    .o_minutes (w_snz.mins)
  );

  assign w_cfg_ok = bus.cfg_we
                 && time_valid(bus.cfg_hours, bus.cfg_minutes)
                 && (32'(bus.cfg_slot) < 32'(NUM_SLOTS));

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_slot_en[i] && (r_slot_h[i] == bus.cur_hours) &&
          (r_slot_m[i] == bus.cur_minutes)) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(i);
      end
    end
  end

  always_comb begin
    w_act_h = 6'd0;
    w_act_m = 6'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_ring_slot == 2'(i)) begin
        w_act_h = r_slot_h[i];
        w_act_m = r_slot_m[i];
      end
    end
  end

  // A write that leaves the active slot enabled at the same time is harmless.
  assign w_act_cfg = w_cfg_ok && (bus.cfg_slot == r_ring_slot) &&
                     (!bus.cfg_enable || (bus.cfg_hours != w_act_h) ||
                      (bus.cfg_minutes != w_act_m));

  assign w_wake_eq = (bus.cur_hours == r_wake.hours) &&
                     (bus.cur_minutes == r_wake.mins);

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_ring_slot;
    w_to_nxt    = r_to_cnt;
    w_sn_nxt    = r_sn_cnt;
    w_wake_nxt  = r_wake;
    case (r_state)
      ST_IDLE: begin
        if (bus.minute_tick && w_hit) begin
          w_state_nxt = ST_RING;
          w_slot_nxt  = w_hit_idx;
          w_to_nxt    = '0;
          w_sn_nxt    = '0;
        end
      end
      ST_RING: begin
        if (w_act_cfg || bus.stop_btn) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.snooze_btn && (r_sn_cnt < c_sn_max)) begin
          w_state_nxt = ST_SNOOZE;
          w_wake_nxt  = w_snz;
          w_sn_nxt    = r_sn_cnt + SN_W'(1);
        end else if (bus.minute_tick) begin
          if (r_to_cnt == c_to_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_to_nxt = r_to_cnt + TO_W'(1);
          end
        end
      end
      ST_SNOOZE: begin
        if (w_act_cfg || bus.stop_btn) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.minute_tick && w_wake_eq) begin
          w_state_nxt = ST_RING;
          w_to_nxt    = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge count or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_state     <= ST_IDLE;
      r_ring      <= 1'b0;
      r_snoozed   <= 1'b0;
      r_ring_slot <= 2'd0;
      r_to_cnt    <= '0;
      r_sn_cnt    <= '0;
      r_wake      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ring      <= (w_state_nxt == ST_RING);
      r_snoozed   <= (w_state_nxt == ST_SNOOZE);
      r_ring_slot <= w_slot_nxt;
      r_to_cnt    <= w_to_nxt;
      r_sn_cnt    <= w_sn_nxt;
      r_wake      <= w_wake_nxt;
    end
  end

  always_ff @(posedge count or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_slot_en <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot_h[i] <= 6'd0;
        r_slot_m[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_cfg_ok && (bus.cfg_slot == 2'(i))) begin
          r_slot_h[i]  <= bus.cfg_hours;
          r_slot_m[i]  <= bus.cfg_minutes;
          r_slot_en[i] <= bus.cfg_enable;
        end
      end
    end
  end

  assign bus.ring      = r_ring;
  assign bus.snoozed   = r_snoozed;
  assign bus.ring_slot = r_ring_slot;
  assign bus.slot_en   = r_slot_en;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_alarm_sched
// Brief  : Directed self-checking bench for alarm_sched.
// Rev    : 1.0
// ============================================================================
module tb_alarm_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alarm_sched_if #(.NUM_SLOTS(4)) bus ();

  alarm_sched #(
    .NUM_SLOTS   (4),
    .SNOOZE_MIN  (5),
    .RING_TIMEOUT(10),
    .MAX_SNOOZE  (3)
  ) dut (
    .count      (clk),
    .reset_in_n (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] s, input logic [5:0] h, input logic [5:0] m,
                     input logic en);
    bus.cfg_we      = 1'b1;
    bus.cfg_slot    = s;
    bus.cfg_hours   = h;
    bus.cfg_minutes = m;
    bus.cfg_enable  = en;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic tick(input logic [5:0] h, input logic [5:0] m);
    bus.cur_hours   = h;
    bus.cur_minutes = m;
    bus.minute_tick = 1'b1;
    @(negedge clk);
    bus.minute_tick = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp);
    bus.snooze_btn = snz;
    bus.stop_btn   = stp;
    @(negedge clk);
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.minute_tick = 1'b0;
    bus.cur_hours   = 6'd0;
    bus.cur_minutes = 6'd0;
    bus.cfg_we      = 1'b0;
    bus.cfg_slot    = 2'd0;
    bus.cfg_hours   = 6'd0;
    bus.cfg_minutes = 6'd0;
    bus.cfg_enable  = 1'b0;
    bus.snooze_btn  = 1'b0;
    bus.stop_btn    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ring", 32'(bus.ring), 32'd0);
    chk("rst_snoozed", 32'(bus.snoozed), 32'd0);
    chk("rst_ring_slot", 32'(bus.ring_slot), 32'd0);
    chk("rst_slot_en", 32'(bus.slot_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic ring on slot 1 at 07:30, then stop
    cfg(2'd1, 6'd7, 6'd30, 1'b1);
    chk("cfg1_en", 32'(bus.slot_en), 32'h2);
    tick(6'd7, 6'd30);
    chk("s1_ring", 32'(bus.ring), 32'd1);
    chk("s1_slot", 32'(bus.ring_slot), 32'd1);
    press(1'b0, 1'b1);
    chk("s1_stop", 32'(bus.ring), 32'd0);

    // Slots 0 and 2 both at 06:00: lowest wins, slot 2 dropped
    cfg(2'd0, 6'd6, 6'd0, 1'b1);
    cfg(2'd2, 6'd6, 6'd0, 1'b1);
    chk("cfg02_en", 32'(bus.slot_en), 32'h7);
    tick(6'd6, 6'd0);
    chk("pri_ring", 32'(bus.ring), 32'd1);
    chk("pri_slot", 32'(bus.ring_slot), 32'd0);
    press(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pri_dropped", 32'(bus.ring), 32'd0);

    // Snooze across midnight, then snooze limit
    cfg(2'd3, 6'd23, 6'd58, 1'b1);
    tick(6'd23, 6'd58);
    chk("mid_ring", 32'(bus.ring), 32'd1);
    chk("mid_slot", 32'(bus.ring_slot), 32'd3);
    press(1'b1, 1'b0);
    chk("snz1_snoozed", 32'(bus.snoozed), 32'd1);
    chk("snz1_ring", 32'(bus.ring), 32'd0);
    chk("snz1_slot", 32'(bus.ring_slot), 32'd3);
    tick(6'd0, 6'd2);
    chk("snz1_early", 32'(bus.snoozed), 32'd1);
    tick(6'd0, 6'd3);
    chk("snz1_wake_ring", 32'(bus.ring), 32'd1);
    chk("snz1_wake_snz", 32'(bus.snoozed), 32'd0);
    press(1'b1, 1'b0);
    chk("snz2_snoozed", 32'(bus.snoozed), 32'd1);
    tick(6'd0, 6'd8);
    chk("snz2_wake", 32'(bus.ring), 32'd1);
    press(1'b1, 1'b0);
    chk("snz3_snoozed", 32'(bus.snoozed), 32'd1);
    tick(6'd0, 6'd13);
    chk("snz3_wake", 32'(bus.ring), 32'd1);
    press(1'b1, 1'b0);
    chk("snz4_ring", 32'(bus.ring), 32'd1);
    chk("snz4_snoozed", 32'(bus.snoozed), 32'd0);
    press(1'b0, 1'b1);
    chk("snz_stop", 32'(bus.ring), 32'd0);

    // Auto-stop after 10 unanswered minute ticks
    tick(6'd23, 6'd58);
    chk("to_ring", 32'(bus.ring), 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick(6'd1, 6'(20 + i));
    end
    chk("to_9", 32'(bus.ring), 32'd1);
    tick(6'd1, 6'd29);
    chk("to_10", 32'(bus.ring), 32'd0);

    // Stop and snooze together: stop wins
    tick(6'd23, 6'd58);
    chk("both_ring", 32'(bus.ring), 32'd1);
    press(1'b1, 1'b1);
    chk("both_ring_off", 32'(bus.ring), 32'd0);
    chk("both_snoozed", 32'(bus.snoozed), 32'd0);

    // Invalid writes ignored
    cfg(2'd0, 6'd6, 6'd0, 1'b0);
    chk("dis0_en", 32'(bus.slot_en), 32'hE);
    cfg(2'd0, 6'd24, 6'd0, 1'b1);
    chk("bad_hour", 32'(bus.slot_en), 32'hE);
    cfg(2'd0, 6'd5, 6'd60, 1'b1);
    chk("bad_min", 32'(bus.slot_en), 32'hE);

    // Disabling the ringing slot forces idle
    tick(6'd7, 6'd30);
    chk("dis_ring", 32'(bus.ring), 32'd1);
    cfg(2'd1, 6'd7, 6'd30, 1'b0);
    chk("dis_idle", 32'(bus.ring), 32'd0);
    chk("dis_en", 32'(bus.slot_en), 32'hC);

    // Asynchronous reset mid-ring
    tick(6'd23, 6'd58);
    chk("arst_pre", 32'(bus.ring), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ring", 32'(bus.ring), 32'd0);
    chk("arst_slot_en", 32'(bus.slot_en), 32'd0);
    chk("arst_slot", 32'(bus.ring_slot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
